// File: rtl/vvp_accum.sv
// vvp_accum -- consumer end of the vvp datapath.
//
// Accumulates the signed partial sums S of one vvp instance over a sequence
// of chunks into one wide signed dot-product result. Each chunk is weighted
// by a left shift (bit-plane significance). A {valid, shift, last} tag is
// captured when a chunk is accepted and delayed by LAT cycles so that it lines
// up with the S value the paired vvp produces for that chunk.
//
// Optional feature: define VVP_ACCUM_SAT_EN for saturating adds plus a sticky
// out_sat flag. Without it, adds wrap modulo 2^ACCW and out_sat is absent.
//
// Parameters
//   N     vvp vector width (S width SW = $clog2(N)+2)
//   LAT   register stages in the paired vvp; tag delay
//   ACCW  accumulator / result width (signed), must exceed SW
//   SHW   shift field width
// Ports
//   clk, rst            clock (rising), async active-high reset
//   in_valid/in_ready   chunk handshake
//   in_shift, in_last   per-chunk weight and end-of-product marker
//   s_in                signed S from vvp, LAT cycles after its chunk
//   out_valid/out_ready result handshake
//   out_data            signed accumulated result
//   busy                product open or tags in flight
//   out_sat             (VVP_ACCUM_SAT_EN only) a clamp occurred in this product
module vvp_accum #(
  parameter int N    = 64,
  parameter int LAT  = 0,
  parameter int ACCW = 32,
  parameter int SHW  = 3,
  localparam int SW  = $clog2(N) + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SHW-1:0]         in_shift,
  input  logic                   in_last,
  input  logic signed [SW-1:0]   s_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_data,
  output logic                   busy
`ifdef VVP_ACCUM_SAT_EN
  ,
  output logic                   out_sat
`endif
);

  if (ACCW <= SW) begin : g_bad_accw
    $error("vvp_accum: ACCW must be wider than SW");
  end

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

  typedef struct packed {
    logic           vld;
    logic [SHW-1:0] sh;
    logic           last;
  } tag_t;

  state_t                 state_q, state_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic signed [ACCW-1:0] sum_n;

  logic accept;
  tag_t tag_new, tag_out;
  logic pipe_busy;

  assign in_ready = (state_q == IDLE) || (state_q == ACC);
  assign accept   = in_valid && in_ready;
  assign tag_new  = {accept, in_shift, in_last};

  // Tag delay line. With no vvp latency the tag applies to s_in in the
  // accepting cycle, so the pipe collapses to a wire.
  if (LAT == 0) begin : g_nolat
    assign tag_out   = tag_new;
    assign pipe_busy = 1'b0;
  end else begin : g_lat
    tag_t [LAT-1:0] tag_pipe_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tag_pipe_q <= '0;
      end else begin
        tag_pipe_q[0] <= tag_new;
        for (int i = 1; i < LAT; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end

    assign tag_out = tag_pipe_q[LAT-1];

    always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < LAT; i++) pipe_busy = pipe_busy | tag_pipe_q[i].vld;
    end
  end

`ifdef VVP_ACCUM_SAT_EN
  // Wide enough for acc + (S << max shift) without loss, so the clamp
  // decision is made on the exact sum.
  localparam int TW = ACCW + (1 << SHW) + 1;

  logic signed [TW-1:0]    term_w, sum_w;
  logic [TW-ACCW:0]        sum_hi;
  logic                    clamp;
  logic                    sat_q, sat_d, out_sat_q, out_sat_d;

  assign term_w = {{(TW-SW){s_in[SW-1]}}, s_in} <<< tag_out.sh;
  assign sum_w  = {{(TW-ACCW){acc_q[ACCW-1]}}, acc_q} + term_w;
  // The sum fits in ACCW bits iff all bits from the ACCW sign bit upward agree.
  assign sum_hi = sum_w[TW-1:ACCW-1];
  assign clamp  = !((sum_hi == '0) || (sum_hi == '1));
  assign sum_n  = !clamp ? sum_w[ACCW-1:0] :
                  sum_w[TW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
  assign out_sat = out_sat_q;
`else
  logic signed [ACCW-1:0] term_n;

  assign term_n = {{(ACCW-SW){s_in[SW-1]}}, s_in} <<< tag_out.sh;
  assign sum_n  = acc_q + term_n;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef VVP_ACCUM_SAT_EN
    sat_d       = sat_q;
    out_sat_d   = out_sat_q;
`endif

    // A chunk contributes when its tag emerges; the last one closes the product.
    if (tag_out.vld) begin
      if (tag_out.last) begin
        out_data_d  = sum_n;
        out_valid_d = 1'b1;
        acc_d       = '0;
`ifdef VVP_ACCUM_SAT_EN
        out_sat_d   = sat_q | clamp;
        sat_d       = 1'b0;
`endif
      end else begin
        acc_d = sum_n;
`ifdef VVP_ACCUM_SAT_EN
        sat_d = sat_q | clamp;
`endif
      end
    end

    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          if (!in_last)      state_d = ACC;
          else if (LAT == 0) state_d = HOLD;
          else               state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_out.vld && tag_out.last) state_d = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
`ifdef VVP_ACCUM_SAT_EN
          out_sat_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef VVP_ACCUM_SAT_EN
      sat_q       <= 1'b0;
      out_sat_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef VVP_ACCUM_SAT_EN
      sat_q       <= sat_d;
      out_sat_q   <= out_sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE) || pipe_busy;

endmodule

// File: tb/tb_vvp_accum.sv
// Bench for vvp_accum. Two instances share one stimulus set, selected by sel:
//   A: N=64,  LAT=0, ACCW=32   B: N=128, LAT=3, ACCW=12
// The vvp latency of B is modelled by a 3-deep delay line on the chunk value.
module tb_vvp_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              sel;
  logic              in_valid, in_last, out_ready;
  logic [2:0]        in_shift;
  logic signed [8:0] chunk_s;
  logic [2:0][8:0]   s_dly = '0;

  logic in_valid_a, in_valid_b;
  logic rdy_a, rdy_b, ov_a, ov_b, busy_a, busy_b;
  logic signed [31:0] od_a;
  logic signed [11:0] od_b;
  logic signed [7:0]  s_a;
  logic signed [8:0]  s_b;

  logic rdy, ov, bsy;
  logic signed [31:0] od;

  assign in_valid_a = in_valid & ~sel;
  assign in_valid_b = in_valid & sel;
  assign s_a = chunk_s[7:0];
  assign s_b = s_dly[2];
  assign rdy = sel ? rdy_b : rdy_a;
  assign ov  = sel ? ov_b : ov_a;
  assign bsy = sel ? busy_b : busy_a;
  assign od  = sel ? {{20{od_b[11]}}, od_b} : od_a;

  always @(posedge clk) s_dly <= {s_dly[1:0], chunk_s};

`ifdef VVP_ACCUM_SAT_EN
  logic sat_a, sat_b, sat_m;
  assign sat_m = sel ? sat_b : sat_a;
`endif

  vvp_accum #(.N(64), .LAT(0), .ACCW(32), .SHW(3)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(rdy_a),
    .in_shift(in_shift), .in_last(in_last), .s_in(s_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .busy(busy_a)
`ifdef VVP_ACCUM_SAT_EN
    , .out_sat(sat_a)
`endif
  );

  vvp_accum #(.N(128), .LAT(3), .ACCW(12), .SHW(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(rdy_b),
    .in_shift(in_shift), .in_last(in_last), .s_in(s_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .busy(busy_b)
`ifdef VVP_ACCUM_SAT_EN
    , .out_sat(sat_b)
`endif
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Scoreboard: expected results queued as stimulus is driven.
  typedef struct {
    int data;
    bit sat;
  } res_t;
  res_t exp_q[$];

  task automatic push_exp(input int d, input bit s);
    res_t r;
    r.data = d;
    r.sat  = s;
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    if (!rst && ov && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result got=%0d", od);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("result_data", od, e.data);
`ifdef VVP_ACCUM_SAT_EN
        chk("result_sat", sat_m, e.sat);
`endif
      end
    end
  end

  // Drives one chunk and returns 1 ns after the edge that accepted it.
  task automatic send(input int s, input int sh, input bit last);
    int n;
    n = 0;
    chunk_s  = 9'(s);
    in_shift = 3'(sh);
    in_last  = last;
    in_valid = 1'b1;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout got=in_ready_low expected=in_ready_high");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  typedef struct {
    bit sel;
    int s;
    int sh;
    bit last;
    int exp;
  } vec_t;
  vec_t vt[13];

  initial begin
    vt[0]  = '{1'b0,   64, 0, 1'b0, 0};
    vt[1]  = '{1'b0,   64, 0, 1'b0, 0};
    vt[2]  = '{1'b0,   64, 0, 1'b0, 0};
    vt[3]  = '{1'b0,   64, 0, 1'b1, 256};
    vt[4]  = '{1'b0, -128, 7, 1'b1, -16384};
    vt[5]  = '{1'b0,   -3, 2, 1'b0, 0};
    vt[6]  = '{1'b0,  100, 0, 1'b1, 88};
    vt[7]  = '{1'b0,  127, 7, 1'b1, 16256};
    vt[8]  = '{1'b1,    3, 0, 1'b0, 0};
    vt[9]  = '{1'b1,   -2, 3, 1'b1, -13};
    vt[10] = '{1'b1,   -1, 0, 1'b0, 0};
    vt[11] = '{1'b1,    2, 1, 1'b0, 0};
    vt[12] = '{1'b1,    1, 2, 1'b1, 7};

    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_shift = '0; chunk_s = '0; out_ready = 1'b1;

    // Reset state of both instances
    repeat (2) @(negedge clk);
    chk("rst_rdy_a", rdy_a, 1);
    chk("rst_ov_a", ov_a, 0);
    chk("rst_od_a", od_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_rdy_b", rdy_b, 1);
    chk("rst_ov_b", ov_b, 0);
    chk("rst_od_b", od_b, 0);
    chk("rst_busy_b", busy_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven products
    for (int i = 0; i < 13; i++) begin
      sel = vt[i].sel;
      if (vt[i].last) push_exp(vt[i].exp, 1'b0);
      send(vt[i].s, vt[i].sh, vt[i].last);
      if (vt[i].last) wait_drain();
    end

    // LAT=3 latency and drain behaviour
    sel = 1'b1;
    send(-1, 0, 0);
    send(2, 1, 0);
    push_exp(7, 1'b0);
    send(1, 2, 1);
    chk("t2_busy_drain", bsy, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t2_no_early_valid", ov, 0);
      chk("t2_rdy_low_drain", rdy, 0);
    end
    @(negedge clk);
    chk("t2_valid_at_latency", ov, 1);
    wait_drain();

    // Backpressure on LAT=0; in_valid during HOLD must be ignored
    sel = 1'b0;
    out_ready = 1'b0;
    send(64, 0, 0);
    send(64, 0, 0);
    send(64, 0, 0);
    push_exp(256, 1'b0);
    send(64, 0, 1);
    chk("t1_valid_next_cycle", ov, 1);
    chunk_s = 9'sd50; in_last = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_data", od, 256);
      chk("t3_hold_valid", ov, 1);
      chk("t3_hold_rdy", rdy, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_rdy_before_hs", rdy, 0);
    @(posedge clk); #1;
    chk("t3_rdy_after_hs", rdy, 1);
    chk("t3_busy_after_hs", bsy, 0);
    wait_drain();
    push_exp(1, 1'b0);
    send(1, 0, 1);
    wait_drain();

    // Async reset with chunks in flight on LAT=3
    sel = 1'b1;
    send(7, 0, 0);
    send(9, 0, 0);
    chk("t4_busy_inflight", bsy, 1);
    rst = 1'b1;
    #1;
    chk("t4_rst_ov", ov, 0);
    chk("t4_rst_od", od, 0);
    chk("t4_rst_rdy", rdy, 1);
    chk("t4_rst_busy", bsy, 0);
    #2;
    rst = 1'b0;
    push_exp(5, 1'b0);
    send(5, 0, 1);
    wait_drain();

    // Long product on ACCW=12: saturates or wraps depending on build
`ifdef VVP_ACCUM_SAT_EN
    push_exp(2047, 1'b1);
`else
    push_exp(1024, 1'b0);
`endif
    for (int k = 0; k < 39; k++) send(128, 0, 0);
    send(128, 0, 1);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
